// File: rtl/jtl_line_emu.sv
// rtl/jtl_line_emu.sv - clocked multi-channel Josephson transmission line emulation model
module jtl_line_emu #(
    parameter int CHANNELS     = 4,
    parameter int DEPTH        = 3,
    parameter int BEGIN_CYCLES = 8,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] a,
    input  logic                viol_clr,
    output logic [CHANNELS-1:0] q,
    output logic                ready,
    output logic [CHANNELS-1:0] viol
);

    // q itself is the last of the DEPTH stages, so only DEPTH-1 shift stages sit in front of it
    localparam int SW = (DEPTH > 1) ? DEPTH - 1 : 1;
    localparam int CW = (BEGIN_CYCLES > 1) ? $clog2(BEGIN_CYCLES) : 1;
    localparam int GW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((BEGIN_CYCLES > 0) ? BEGIN_CYCLES - 1 : 0);
    localparam logic [GW-1:0] HOLD_V   = GW'(HOLD_CYCLES);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [CHANNELS-1:0]             a_prev_q, a_prev_d;
    logic [CHANNELS-1:0][GW-1:0]     gap_q, gap_d;
    logic [SW-1:0][CHANNELS-1:0]     sh_q, sh_d;
    logic [CHANNELS-1:0]             q_q, q_d;
    logic [CHANNELS-1:0]             viol_q, viol_d;
    logic [CHANNELS-1:0]             pulse;
    logic [CHANNELS-1:0]             acc;
    logic [CHANNELS-1:0]             tap;

    // Blanking sequencer: count out the startup window, then stay in RUN until reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BLANK: begin
                if (BEGIN_CYCLES == 0 || cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_BLANK;
            end
        endcase
    end

    // Per-channel pulse detect, hold check, delay line and output toggle
    always_comb begin
        a_prev_d = a;
        gap_d    = gap_q;
        viol_d   = viol_q & ~{CHANNELS{viol_clr}};
        acc      = '0;
        pulse    = (state_q == ST_RUN) ? (a ^ a_prev_q) : '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pulse[i]) begin
                gap_d[i] = '0;
                if (gap_q[i] >= HOLD_V) begin
                    acc[i] = 1'b1;
                end else begin
                    viol_d[i] = 1'b1;
                end
            end else if (gap_q[i] != HOLD_V) begin
                gap_d[i] = gap_q[i] + 1'b1;
            end
        end
        sh_d[0] = acc;
        for (int j = 1; j < SW; j++) begin
            sh_d[j] = sh_q[j-1];
        end
        tap = (DEPTH == 1) ? acc : sh_q[SW-1];
        q_d = q_q ^ tap;
    end

    // State registers; reset drops in-flight pulses and re-arms blanking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_BLANK;
            cnt_q    <= '0;
            a_prev_q <= a;
            gap_q    <= {CHANNELS{HOLD_V}};
            sh_q     <= '0;
            q_q      <= '0;
            viol_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_prev_q <= a_prev_d;
            gap_q    <= gap_d;
            sh_q     <= sh_d;
            q_q      <= q_d;
            viol_q   <= viol_d;
        end
    end

    assign q     = q_q;
    assign viol  = viol_q;
    assign ready = (state_q == ST_RUN);

endmodule

// File: tb/tb_jtl_line_emu.sv
// tb/tb_jtl_line_emu.sv - randomized and directed bench for jtl_line_emu against an edge-event model
module tb_jtl_line_emu;

    localparam int CH = 4;
    localparam int DP = 3;
    localparam int BC = 8;
    localparam int HC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] a = '0;
    logic          viol_clr = 1'b0;
    logic [CH-1:0] q;
    logic          ready;
    logic [CH-1:0] viol;

    int vectors = 0;
    int miscompares = 0;

    // reference model state: absolute edge numbers, not register contents
    int            edge_n = 0;
    int            rel = 0;
    int            last_det [CH];
    int            pend [CH][$];
    logic [CH-1:0] m_aprev = '0;
    logic [CH-1:0] m_q = '0;
    logic [CH-1:0] m_viol = '0;
    logic          m_ready = 1'b0;

    jtl_line_emu #(
        .CHANNELS(CH),
        .DEPTH(DP),
        .BEGIN_CYCLES(BC),
        .HOLD_CYCLES(HC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .a(a),
        .viol_clr(viol_clr),
        .q(q),
        .ready(ready),
        .viol(viol)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic [CH-1:0] rej;
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            rel = 0;
            m_q = '0;
            m_viol = '0;
            for (int c = 0; c < CH; c++) begin
                pend[c].delete();
                last_det[c] = -1000;
            end
        end else begin
            rej = '0;
            for (int c = 0; c < CH; c++) begin
                if (rel >= BC && a[c] != m_aprev[c]) begin
                    if (edge_n - last_det[c] > HC) pend[c].push_back(edge_n + DP - 1);
                    else rej[c] = 1'b1;
                    last_det[c] = edge_n;
                end
                while (pend[c].size() > 0 && pend[c][0] == edge_n) begin
                    void'(pend[c].pop_front());
                    m_q[c] = ~m_q[c];
                end
            end
            m_viol = (viol_clr ? '0 : m_viol) | rej;
            rel++;
        end
        m_aprev = a;
        m_ready = (rel >= BC);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = '0;
        viol_clr = 1'b0;
        tick();
        tick();
        vectors++;
        if ({q, ready, viol} !== {4'h0, 1'b0, 4'h0}) begin
            miscompares++;
            $display("FAIL reset_state q/ready/viol=%h/%b/%h want 0/0/0", q, ready, viol);
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            if (n == 3) a[0] = ~a[0];
            tick();
            vectors++;
            if ({q, ready, viol} !== {m_q, m_ready, m_viol} || q !== 4'h0 || ready !== (n >= BC)) begin
                miscompares++;
                $display("FAIL blanking edge %0d q/ready/viol=%h/%b/%h want %h/%b/%h", n, q, ready, viol, m_q, m_ready, m_viol);
            end
        end
    endtask

    task automatic test_latency();
        logic [CH-1:0] q0;
        q0 = q;
        a[1] = ~a[1];
        for (int n = 0; n < 5; n++) begin
            tick();
            vectors++;
            if ({q, viol} !== {m_q, m_viol} || q !== (q0 ^ ((n >= 2) ? 4'b0010 : 4'b0000)) || viol !== 4'h0) begin
                miscompares++;
                $display("FAIL latency k+%0d q/viol=%h/%h want %h/%h", n, q, viol, m_q, m_viol);
            end
        end
    endtask

    task automatic test_hold();
        logic [CH-1:0] q0;
        q0 = q;
        for (int n = 0; n < 8; n++) begin
            if (n == 0 || n == 1 || n == 4) a[2] = ~a[2];
            tick();
            vectors++;
            if ({q, viol} !== {m_q, m_viol} ||
                q[2] !== (q0[2] ^ (n >= 2) ^ (n >= 6)) || viol[2] !== (n >= 1)) begin
                miscompares++;
                $display("FAIL hold k+%0d q/viol=%h/%h want %h/%h", n, q, viol, m_q, m_viol);
            end
        end
    endtask

    task automatic test_clear();
        viol_clr = 1'b1;
        tick();
        viol_clr = 1'b0;
        vectors++;
        if (viol !== 4'h0 || viol !== m_viol) begin
            miscompares++;
            $display("FAIL clear_alone viol=%h want 0", viol);
        end
        repeat (3) tick();
        a[2] = ~a[2];
        tick();
        a[2] = ~a[2];
        viol_clr = 1'b1;
        tick();
        viol_clr = 1'b0;
        vectors++;
        if (viol[2] !== 1'b1 || viol !== m_viol) begin
            miscompares++;
            $display("FAIL clear_vs_new viol=%h want %h", viol, m_viol);
        end
        repeat (4) tick();
    endtask

    task automatic test_parallel();
        logic [CH-1:0] q0;
        viol_clr = 1'b1;
        tick();
        viol_clr = 1'b0;
        repeat (3) tick();
        q0 = q;
        a = ~a;
        for (int n = 0; n < 4; n++) begin
            tick();
            vectors++;
            if ({q, viol} !== {m_q, m_viol} || q !== ((n >= 2) ? ~q0 : q0) || viol !== 4'h0) begin
                miscompares++;
                $display("FAIL parallel k+%0d q/viol=%h/%h want %h/%h", n, q, viol, m_q, m_viol);
            end
        end
    endtask

    task automatic test_reset_inflight();
        a[3] = ~a[3];
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            vectors++;
            if ({q, ready, viol} !== {m_q, m_ready, m_viol} || q !== 4'h0 || ready !== (n >= BC)) begin
                miscompares++;
                $display("FAIL reset_inflight +%0d q/ready/viol=%h/%b/%h want %h/%b/%h", n, q, ready, viol, m_q, m_ready, m_viol);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            a = a ^ CH'($urandom_range(0, 15) & $urandom_range(0, 15));
            viol_clr = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
            vectors++;
            if ({q, ready, viol} !== {m_q, m_ready, m_viol}) begin
                miscompares++;
                $display("FAIL random edge %0d q/ready/viol=%h/%b/%h want %h/%b/%h", edge_n, q, ready, viol, m_q, m_ready, m_viol);
            end
        end
        rst_n = 1'b1;
        viol_clr = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < CH; c++) last_det[c] = -1000;
        test_reset();
        test_latency();
        test_hold();
        test_clear();
        test_parallel();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
